// File: rtl/f2i_ctrl_pkg.sv
// Shared definitions for controllers that time-share a float/int converter.
package f2i_ctrl_pkg;

  localparam int FLOAT_W     = 32;
  localparam int INT_W       = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 16;

  // One conversion in flight: grant, hand operand over, drain result, return it.
  typedef enum logic [2:0] {
    ARB    = 3'd0,
    ACCEPT = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } f2i_state_e;

endpackage

// File: rtl/f2i_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo NUM_REQ. i_ptr is expected to be below NUM_REQ.
module rr_pick import f2i_ctrl_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  localparam logic [IDX_W:0] LIM = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] w_sum;

  // Scan offsets from far to near so the nearest requester after i_ptr wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(k);
      w_sum   = (w_sum >= LIM) ? (w_sum - LIM) : w_sum;
      o_valid = i_req[w_sum[IDX_W-1:0]] ? 1'b1 : o_valid;
      o_idx   = i_req[w_sum[IDX_W-1:0]] ? w_sum[IDX_W-1:0] : o_idx;
    end
  end

endmodule

// File: rtl/f2i_share_ctrl.sv
// Round-robin share of one float-to-int32 converter between NUM_REQ
// requesters. Exactly one conversion is in flight; a pending result blocks
// new grants until its requester consumes it. All outputs are registered.
module f2i_share_ctrl import f2i_ctrl_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*FLOAT_W-1:0] req_a,
  input  logic [NUM_REQ-1:0]         req_stb,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [INT_W-1:0]           resp_z,
  output logic [NUM_REQ-1:0]         resp_stb,
  input  logic [NUM_REQ-1:0]         resp_ack,
  output logic [FLOAT_W-1:0]         cvt_a,
  output logic                       cvt_a_stb,
  input  logic                       cvt_a_ack,
  input  logic [INT_W-1:0]           cvt_z,
  input  logic                       cvt_z_stb,
  output logic                       cvt_z_ack,
  output logic                       busy,
  output logic [CNT_W-1:0]           conv_count
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  f2i_state_e         r_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [NUM_REQ-1:0] r_resp_stb;
  logic [INT_W-1:0]   r_resp_z;
  logic [FLOAT_W-1:0] r_cvt_a;
  logic               r_cvt_a_stb;
  logic               r_cvt_z_ack;
  logic               r_busy;
  logic [CNT_W-1:0]   r_conv_count;

  f2i_state_e         w_state_nxt;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_req_ack_nxt;
  logic [NUM_REQ-1:0] w_resp_stb_nxt;
  logic [INT_W-1:0]   w_resp_z_nxt;
  logic [FLOAT_W-1:0] w_cvt_a_nxt;
  logic               w_cvt_a_stb_nxt;
  logic               w_cvt_z_ack_nxt;
  logic               w_busy_nxt;
  logic [CNT_W-1:0]   w_count_nxt;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [FLOAT_W-1:0] w_req_a [NUM_REQ];

  // Per-requester operand view of the flat operand bus.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_a[gi] = req_a[gi*FLOAT_W +: FLOAT_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (req_stb),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-state and next-output logic; every register holds unless its state acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_req_ack_nxt   = r_req_ack;
    w_resp_stb_nxt  = r_resp_stb;
    w_resp_z_nxt    = r_resp_z;
    w_cvt_a_nxt     = r_cvt_a;
    w_cvt_a_stb_nxt = r_cvt_a_stb;
    w_cvt_z_ack_nxt = r_cvt_z_ack;
    w_count_nxt     = r_conv_count;
    case (r_state)
      ARB: begin
        if (w_pick_valid) begin
          w_grant_nxt   = w_pick_idx;
          w_req_ack_nxt = onehot(w_pick_idx);
          w_state_nxt   = ACCEPT;
        end else begin
          w_state_nxt   = ARB;
        end
      end
      ACCEPT: begin
        w_req_ack_nxt = '0;
        if (req_stb[r_grant]) begin
          w_cvt_a_nxt     = w_req_a[r_grant];
          w_cvt_a_stb_nxt = 1'b1;
          w_state_nxt     = SEND;
        end else begin
          // Requester withdrew before the transfer: abandon without moving rr_ptr.
          w_state_nxt     = ARB;
        end
      end
      SEND: begin
        if (cvt_a_ack) begin
          w_cvt_a_stb_nxt = 1'b0;
          w_cvt_z_ack_nxt = 1'b1;
          w_state_nxt     = WAIT;
        end else begin
          w_state_nxt     = SEND;
        end
      end
      WAIT: begin
        if (cvt_z_stb) begin
          w_resp_z_nxt    = cvt_z;
          w_cvt_z_ack_nxt = 1'b0;
          w_resp_stb_nxt  = onehot(r_grant);
          w_state_nxt     = RESP;
        end else begin
          w_state_nxt     = WAIT;
        end
      end
      RESP: begin
        if (resp_ack[r_grant]) begin
          w_resp_stb_nxt = '0;
          w_rr_ptr_nxt   = (r_grant == LAST_IDX) ? '0 : (r_grant + IDX_ONE);
          w_count_nxt    = r_conv_count + CNT_ONE;
          w_state_nxt    = ARB;
        end else begin
          w_state_nxt    = RESP;
        end
      end
      default: begin
        w_req_ack_nxt   = '0;
        w_resp_stb_nxt  = '0;
        w_cvt_a_stb_nxt = 1'b0;
        w_cvt_z_ack_nxt = 1'b0;
        w_state_nxt     = ARB;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ARB);
  end

  // State and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ARB;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_req_ack    <= '0;
      r_resp_stb   <= '0;
      r_resp_z     <= '0;
      r_cvt_a      <= '0;
      r_cvt_a_stb  <= 1'b0;
      r_cvt_z_ack  <= 1'b0;
      r_busy       <= 1'b0;
      r_conv_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_req_ack    <= w_req_ack_nxt;
      r_resp_stb   <= w_resp_stb_nxt;
      r_resp_z     <= w_resp_z_nxt;
      r_cvt_a      <= w_cvt_a_nxt;
      r_cvt_a_stb  <= w_cvt_a_stb_nxt;
      r_cvt_z_ack  <= w_cvt_z_ack_nxt;
      r_busy       <= w_busy_nxt;
      r_conv_count <= w_count_nxt;
    end
  end

  assign req_ack    = r_req_ack;
  assign resp_z     = r_resp_z;
  assign resp_stb   = r_resp_stb;
  assign cvt_a      = r_cvt_a;
  assign cvt_a_stb  = r_cvt_a_stb;
  assign cvt_z_ack  = r_cvt_z_ack;
  assign busy       = r_busy;
  assign conv_count = r_conv_count;

endmodule

// File: tb/tb_f2i_share_ctrl.sv
// Directed and randomized bench for f2i_share_ctrl. The bench plays the
// requesters and the shared converter; expected grants come from a plain
// round-robin model over the bench's own request vector.
module tb_f2i_share_ctrl;

  localparam int NREQ = 4;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ-1:0]   req_stb;
  logic [NREQ-1:0]   req_ack;
  logic [31:0]       resp_z;
  logic [NREQ-1:0]   resp_stb;
  logic [NREQ-1:0]   resp_ack;
  logic [31:0]       cvt_a;
  logic              cvt_a_stb;
  logic              cvt_a_ack;
  logic [31:0]       cvt_z;
  logic              cvt_z_stb;
  logic              cvt_z_ack;
  logic              busy;
  logic [CW-1:0]     conv_count;

  int total = 0;
  int bad   = 0;
  int ptr   = 0;   // model round-robin pointer
  int count = 0;   // model completed conversions
  int gq[$];       // observed grant order

  f2i_share_ctrl #(.NUM_REQ(NREQ), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .req_stb    (req_stb),
    .req_ack    (req_ack),
    .resp_z     (resp_z),
    .resp_stb   (resp_stb),
    .resp_ack   (resp_ack),
    .cvt_a      (cvt_a),
    .cvt_a_stb  (cvt_a_stb),
    .cvt_a_ack  (cvt_a_ack),
    .cvt_z      (cvt_z),
    .cvt_z_stb  (cvt_z_stb),
    .cvt_z_ack  (cvt_z_ack),
    .busy       (busy),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Truncating IEEE single to int32; out-of-range and NaN give 0x80000000.
  function automatic logic [31:0] f2i(input logic [31:0] f);
    int e;
    logic [31:0] mag;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 32'h0000_0000;
    if (e > 30) return 32'h8000_0000;
    mag = {8'h00, 1'b1, f[22:0]};
    if (e >= 23) mag = mag << (e - 23);
    else         mag = mag >> (23 - e);
    return f[31] ? (~mag + 32'd1) : mag;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++)
      if (req_stb[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic int first_set(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_float();
    return {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_req_ack"},   32'(req_ack),    32'h0);
    chk({tag, "_resp_stb"},  32'(resp_stb),   32'h0);
    chk({tag, "_cvt_a_stb"}, 32'(cvt_a_stb),  32'h0);
    chk({tag, "_cvt_z_ack"}, 32'(cvt_z_ack),  32'h0);
    chk({tag, "_busy"},      32'(busy),       32'h0);
    chk({tag, "_count"},     32'(conv_count), 32'(count));
  endtask

  // One full transaction for the requester the model expects to win.
  task automatic serve(input bit keep, input logic [NREQ-1:0] raise_after,
                       input int a_lat, input int z_lat, input int r_lat);
    int g;
    int n;
    logic [31:0] opnd;
    logic [31:0] res;
    g    = model_pick();
    opnd = req_a[g*32 +: 32];
    res  = f2i(opnd);
    n    = 0;
    while (req_ack === '0 && n < 20) begin
      tick();
      n++;
    end
    chk("ack_latency", 32'(n), 32'd1);
    chk("grant", 32'(req_ack), 32'(oh(g)));
    chk("busy_on", 32'(busy), 32'h1);
    gq.push_back(first_set(req_ack));
    tick();
    req_stb[g] = keep;
    if (keep) req_a[g*32 +: 32] = rnd_float();
    for (int i = 0; i < NREQ; i++) begin
      if (raise_after[i]) begin
        req_stb[i] = 1'b1;
        req_a[i*32 +: 32] = rnd_float();
      end
    end
    chk("ack_clear", 32'(req_ack), 32'h0);
    chk("cvt_a_stb_on", 32'(cvt_a_stb), 32'h1);
    chk("cvt_a", cvt_a, opnd);
    for (int i = 0; i < a_lat; i++) begin
      tick();
      chk("cvt_a_hold", {cvt_a[30:0], cvt_a_stb}, {opnd[30:0], 1'b1});
    end
    cvt_a_ack = 1'b1;
    tick();
    cvt_a_ack = 1'b0;
    chk("cvt_a_stb_off", 32'(cvt_a_stb), 32'h0);
    chk("cvt_z_ack_on", 32'(cvt_z_ack), 32'h1);
    for (int i = 0; i < z_lat; i++) begin
      cvt_z = $urandom;
      tick();
      chk("wait_hold", {31'(resp_stb), cvt_z_ack}, 32'h1);
    end
    cvt_z     = res;
    cvt_z_stb = 1'b1;
    tick();
    cvt_z_stb = 1'b0;
    cvt_z     = $urandom;
    chk("cvt_z_ack_off", 32'(cvt_z_ack), 32'h0);
    chk("resp_stb", 32'(resp_stb), 32'(oh(g)));
    chk("resp_z", resp_z, res);
    for (int i = 0; i < r_lat; i++) begin
      resp_ack = 4'($urandom) & ~oh(g);
      tick();
      chk("bp_resp_stb", 32'(resp_stb), 32'(oh(g)));
      chk("bp_resp_z", resp_z, res);
      chk("bp_quiet", {30'(req_ack), cvt_a_stb, cvt_z_ack}, 32'h0);
    end
    resp_ack = oh(g);
    tick();
    resp_ack = '0;
    count++;
    ptr = (g + 1) % NREQ;
    chk("resp_done", 32'(resp_stb), 32'h0);
    chk("count", 32'(conv_count), 32'(count));
    chk("busy_off", 32'(busy), 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    ptr   = 0;
    count = 0;
  endtask

  initial begin
    int n;
    int exp_order[10];
    rst_n     = 1'b0;
    req_a     = '0;
    req_stb   = '0;
    resp_ack  = '0;
    cvt_a_ack = 1'b0;
    cvt_z     = '0;
    cvt_z_stb = 1'b0;

    // Reset values.
    do_reset(2);
    check_idle("rst");
    chk("rst_resp_z", resp_z, 32'h0);
    chk("rst_cvt_a", cvt_a, 32'h0);

    // Single request: 1.0 from requester 0.
    req_a[0*32 +: 32] = 32'h3F80_0000;
    req_stb[0] = 1'b1;
    serve(1'b0, '0, 0, 0, 0);
    chk("one_z", resp_z, 32'h0000_0001);
    chk("one_count", 32'(conv_count), 32'd1);

    // Negative truncation and 2^31 from requester 1.
    req_a[1*32 +: 32] = 32'hC020_0000;
    req_stb[1] = 1'b1;
    serve(1'b0, '0, 1, 2, 1);
    chk("neg_z", resp_z, 32'hFFFF_FFFE);
    req_a[1*32 +: 32] = 32'h4F00_0000;
    req_stb[1] = 1'b1;
    serve(1'b0, '0, 2, 0, 0);
    chk("big_z", resp_z, 32'h8000_0000);

    // Contention after reset: 0 and 2 together, then all four continuously.
    do_reset(1);
    check_idle("rst2");
    gq.delete();
    req_a[0*32 +: 32] = rnd_float();
    req_a[2*32 +: 32] = rnd_float();
    req_stb = 4'b0101;
    serve(1'b0, '0, 0, 1, 0);
    serve(1'b0, '0, 1, 0, 1);
    for (int i = 0; i < NREQ; i++) req_a[i*32 +: 32] = rnd_float();
    req_stb = 4'b1111;
    for (int i = 0; i < 8; i++)
      serve(1'b1, '0, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    exp_order = '{0, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    for (int i = 0; i < 10; i++)
      chk($sformatf("order%0d", i), 32'(gq[i]), 32'(exp_order[i]));
    req_stb = '0;

    // Backpressure: requester 1 holds its result for 10 cycles while others wait.
    req_a[1*32 +: 32] = rnd_float();
    req_stb[1] = 1'b1;
    gq.delete();
    serve(1'b0, 4'b1101, 1, 1, 10);
    chk("bp_grant", 32'(gq[0]), 32'd1);
    for (int i = 0; i < 3; i++) serve(1'b0, '0, 0, 1, 1);

    // Reset while waiting for the converter result.
    req_a[2*32 +: 32] = 32'h42F6_E979;
    req_stb[2] = 1'b1;
    n = 0;
    while (req_ack === '0 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_grant", 32'(req_ack), 32'(oh(2)));
    tick();
    req_stb[2] = 1'b0;
    cvt_a_ack = 1'b1;
    tick();
    cvt_a_ack = 1'b0;
    chk("mid_in_wait", 32'(cvt_z_ack), 32'h1);
    do_reset(1);
    check_idle("mid_rst");
    tick();
    check_idle("mid_after");
    req_a[1*32 +: 32] = rnd_float();
    req_a[3*32 +: 32] = rnd_float();
    req_stb = 4'b1010;
    serve(1'b0, '0, 1, 1, 1);
    serve(1'b0, '0, 0, 0, 0);

    // Requester 3 withdraws during ACCEPT.
    req_a[3*32 +: 32] = rnd_float();
    req_stb[3] = 1'b1;
    n = 0;
    while (req_ack === '0 && n < 20) begin
      tick();
      n++;
    end
    chk("viol_grant", 32'(req_ack), 32'(oh(3)));
    req_stb[3] = 1'b0;
    tick();
    check_idle("viol");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("viol_hold");
    end
    req_stb = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_a[i*32 +: 32] = rnd_float();
    for (int i = 0; i < NREQ; i++) serve(1'b0, '0, 0, 1, 0);

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 24; it++) begin
      logic [NREQ-1:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (m[i] && !req_stb[i]) begin
          req_stb[i] = 1'b1;
          req_a[i*32 +: 32] = rnd_float();
        end
      end
      serve(1'b0, '0, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_stb != '0) serve(1'b0, '0, 0, 0, 0);
    end
    check_idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f2i_share_ctrl.md
Name: f2i_share_ctrl

Overview:
- Shares one float2int converter between NUM_REQ requesters; the converter converts IEEE single to int32 and has stb/ack handshakes on input and output.
- Round-robin arbitration across requesters; one conversion in flight at a time.
- Drives the converter's input port and drains its output port, then returns the result to the granted requester.
- Sits between the per-lane float producers and the shared converter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 16, width of the completed-conversion counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low. Also drives the converter's reset through an inverter at the parent.
- req_a  in  NUM_REQ*32  float operands; requester i occupies bits [32i+31:32i].
- req_stb  in  NUM_REQ  request strobe; held high until acked.
- req_ack  out  NUM_REQ  operand accepted; one-hot or zero.
- resp_z  out  32  int32 result for the granted requester.
- resp_stb  out  NUM_REQ  result valid; one-hot or zero.
- resp_ack  in  NUM_REQ  result consumed.
- cvt_a  out  32  operand to the converter input_a.
- cvt_a_stb  out  1  to the converter input_a_stb.
- cvt_a_ack  in  1  from the converter input_a_ack.
- cvt_z  in  32  from the converter output_z.
- cvt_z_stb  in  1  from the converter output_z_stb.
- cvt_z_ack  out  1  to the converter output_z_ack.
- busy  out  1  high in any state except ARB.
- conv_count  out  CNT_W  completed conversions; wraps at 2^CNT_W.

Behaviour:
- Handshake rule on every port: a transfer occurs on a rising edge where stb and ack are both high.
- All outputs are registered. On reset:
  - req_ack = 0, resp_stb = 0, cvt_a_stb = 0, cvt_z_ack = 0, busy = 0.
  - conv_count = 0, rr_ptr = 0, state = ARB.
  - resp_z and cvt_a = 0.
- State ARB:
  - If any req_stb is high, the grant is the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant g, set req_ack[g] = 1, go to ACCEPT.
  - Otherwise stay in ARB.
- State ACCEPT:
  - If req_stb[g] is high: capture cvt_a <= req_a[g], clear req_ack, set cvt_a_stb = 1, go to SEND.
  - If req_stb[g] has dropped (protocol violation): clear req_ack and return to ARB. rr_ptr is unchanged.
- State SEND:
  - Hold cvt_a_stb and cvt_a stable until cvt_a_ack is high.
  - Then clear cvt_a_stb, set cvt_z_ack = 1, go to WAIT.
- State WAIT:
  - Hold cvt_z_ack high until cvt_z_stb is high.
  - Then capture resp_z <= cvt_z, clear cvt_z_ack, set resp_stb[g] = 1, go to RESP.
- State RESP:
  - Hold resp_stb[g] and resp_z stable until resp_ack[g] is high.
  - Then clear resp_stb, set rr_ptr = (g+1) mod NUM_REQ, increment conv_count, go to ARB.
  - No new grant while a result is pending (backpressure stalls the converter share).
- Latency: request edge to req_ack = 1 cycle. Minimum total latency = 2 (ARB, ACCEPT) + converter latency + 1 (capture) cycles.
- Simultaneous requests: exactly one grant per ARB visit. Requests that lose keep stb high and are served in round-robin order. No starvation: bounded by NUM_REQ conversions.
- The controller ignores resp_ack and req_stb of non-granted requesters.
- Reset asserted in any state forces the reset values on the next edge. A result in flight is discarded and not counted.

Decomposition:
- Package f2i_ctrl_pkg:
  - State enum ARB/ACCEPT/SEND/WAIT/RESP (3-bit).
  - FLOAT_W = 32, INT_W = 32.
  - Default NUM_REQ.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector, rr_ptr. Outputs: valid, grant index.
  - Reusable by later shared-datapath controllers.

Test Plan:
- Single request: requester 0 sends 0x3F800000 (1.0) → resp_z = 0x00000001 on resp_stb[0], conv_count = 1.
- Negative truncation: requester 1 sends 0xC0200000 (-2.5) → resp_z = 0xFFFFFFFE. Also 0x4F000000 (2^31) → 0x80000000.
- Contention: after reset, requesters 0 and 2 both strobe in the same cycle.
  - Required order is 0 then 2.
  - Then all four strobe continuously for 8 conversions → grant order 3,0,1,2,3,0,1,2.
- Backpressure: hold resp_ack[1] low for 10 cycles.
  - resp_stb[1] and resp_z stay stable.
  - cvt_a_stb stays low and req_ack stays 0 for the others.
  - Completion occurs one cycle after resp_ack rises.
- Reset mid-op: drop rst_n for one cycle while in WAIT.
  - Next cycle all strobes and acks are 0, busy = 0, conv_count = 0.
  - A fresh request completes normally.
- Protocol violation: drop req_stb[3] during ACCEPT → no cvt_a_stb pulse, return to ARB, conv_count unchanged.
